// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN layer engines
// that answer the layer sequencer's run/done handshake.
package cnn_pkg;

  localparam int RUN_PULSE_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    DRAIN = 3'd2,
    WR    = 3'd3,
    FIN   = 3'd4
  } maxpool_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: window-read and pooled-write addresses for the
// 2x2 stride-2 max-pool engine; all arithmetic wraps at ADDR_W bits.
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic [DIM_W-1:0]  c,
  input  logic [DIM_W-1:0]  oy,
  input  logic [DIM_W-1:0]  ox,
  input  logic [1:0]        k,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  oh,
  input  logic [DIM_W-1:0]  ow,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr
);

  typedef logic [ADDR_W-1:0] addr_t;

  addr_t c_a;
  addr_t h_a;
  addr_t w_a;
  addr_t oh_a;
  addr_t ow_a;
  addr_t oy_a;
  addr_t ox_a;
  addr_t y_a;
  addr_t x_a;

  assign c_a  = addr_t'(c);
  assign h_a  = addr_t'(cfg_h);
  assign w_a  = addr_t'(cfg_w);
  assign oh_a = addr_t'(oh);
  assign ow_a = addr_t'(ow);
  assign oy_a = addr_t'(oy);
  assign ox_a = addr_t'(ox);

  // k[1] selects the lower row of the window, k[0] the right column
  assign y_a = (oy_a << 1) + addr_t'(k[1]);
  assign x_a = (ox_a << 1) + addr_t'(k[0]);

  assign rd_addr = in_base + c_a * h_a * w_a
                 + y_a * w_a + x_a;

  assign wr_addr = out_base + c_a * oh_a * ow_a
                 + oy_a * ow_a + ox_a;

endmodule

// File: rtl/maxpool_engine.sv
// maxpool_engine: 2x2 stride-2 signed max-pool layer engine over a
// channel-major map in shared buffer memory, run/done handshake.
module maxpool_engine
  import cnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [DIM_W-1:0]  cfg_c,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] out_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  maxpool_state_t state;
  maxpool_state_t state_d;

  logic [DIM_W-1:0]  h_q;
  logic [DIM_W-1:0]  w_q;
  logic [DIM_W-1:0]  c_q;
  logic [DIM_W-1:0]  oh_q;
  logic [DIM_W-1:0]  ow_q;
  logic [ADDR_W-1:0] ib_q;
  logic [ADDR_W-1:0] ob_q;

  logic [DIM_W-1:0]  c_cnt;
  logic [DIM_W-1:0]  oy;
  logic [DIM_W-1:0]  ox;
  logic [1:0]        k;

  logic signed [DATA_W-1:0] acc;
  logic s_vld;
  logic s_first;

  logic empty;
  logic ox_end;
  logic oy_end;
  logic c_end;
  logic last;

  assign empty  = (cfg_h < DIM_W'(2))
               || (cfg_w < DIM_W'(2))
               || (cfg_c == '0);
  assign ox_end = ox == ow_q - DIM_W'(1);
  assign oy_end = oy == oh_q - DIM_W'(1);
  assign c_end  = c_cnt == c_q - DIM_W'(1);
  assign last   = ox_end && oy_end && c_end;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_d = empty ? FIN : RD;
        end
      end
      RD: begin
        if (k == 2'd3) begin
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = WR;
      WR: state_d = last ? FIN : RD;
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= '0;
      w_q   <= '0;
      c_q   <= '0;
      oh_q  <= '0;
      ow_q  <= '0;
      ib_q  <= '0;
      ob_q  <= '0;
      c_cnt <= '0;
      oy    <= '0;
      ox    <= '0;
      k     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) begin
            h_q   <= cfg_h;
            w_q   <= cfg_w;
            c_q   <= cfg_c;
            oh_q  <= cfg_h >> 1;
            ow_q  <= cfg_w >> 1;
            ib_q  <= in_base;
            ob_q  <= out_base;
            c_cnt <= '0;
            oy    <= '0;
            ox    <= '0;
            k     <= '0;
          end
        end
        RD: k <= k + 2'd1;
        WR: begin
          // raster order within a channel, then next channel
          ox <= ox_end ? '0 : ox + DIM_W'(1);
          if (ox_end) begin
            oy <= oy_end ? '0 : oy + DIM_W'(1);
            if (oy_end) begin
              c_cnt <= c_end ? '0 : c_cnt + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // read data lands one cycle after its strobe, so the
  // fold runs one cycle behind the read and ends in DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_vld   <= 1'b0;
      s_first <= 1'b0;
      acc     <= '0;
    end else begin
      s_vld   <= state == RD;
      s_first <= (state == RD) && (k == 2'd0);
      if (s_vld && (s_first || $signed(rd_data) > acc)) begin
        acc <= $signed(rd_data);
      end
    end
  end

  assign busy    = state != IDLE;
  assign done    = state == FIN;
  assign rd_en   = state == RD;
  assign wr_en   = state == WR;
  assign wr_data = acc;

  pool_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr (
    .c        (c_cnt),
    .oy       (oy),
    .ox       (ox),
    .k        (k),
    .cfg_h    (h_q),
    .cfg_w    (w_q),
    .oh       (oh_q),
    .ow       (ow_q),
    .in_base  (ib_q),
    .out_base (ob_q),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr)
  );

endmodule
